vga_text_buffer: RTL and testbench

//  Parametrised text-mode video memory between the PS/2 key decoder and the VGA

---
 rtl/vga_text_buffer.sv | 192 +++++++++++++++++++
 tb/tb_vga_text_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_buffer.sv
// vga_text_buffer: text-mode video memory between the PS/2 key decoder and the
// VGA character renderer.
//
// It holds a COLS x ROWS ASCII screen and a write cursor, and handles printable
// keys, ENTER and BACKSPACE. The screen scrolls by moving a circular top-row
// offset, so no lines are copied. For the current scan position it serves the
// character and the pixel offset inside its cell to the font ROM.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   key_in, key_valid      ASCII key from the decoder, consumed when key_ready is high
//   key_ready              high only in IDLE
//   h_addr, v_addr         VGA pixel address
//   ascii_out, row, col    character and in-cell pixel offset, one cycle after the address
//   cur_x, cur_y           cursor position, relative to the screen
//   busy                   high while a CLEAR or SCROLL sweep is in progress
module vga_text_buffer #(
  parameter int unsigned COLS   = 70,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned CHAR_W = 9,
  parameter int unsigned CHAR_H = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [9:0] h_addr,
  input  logic [9:0] v_addr,
  output logic [7:0] ascii_out,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic       busy
);

  localparam int unsigned Cells = COLS * ROWS;
  localparam int unsigned AddrW = $clog2(Cells);

  typedef enum logic [1:0] {StClear, StIdle, StScroll} state_e;

  state_e           state;
  logic [AddrW-1:0] cnt;    // sweep position in CLEAR (address) and SCROLL (column)
  logic [4:0]       top;    // physical line shown on screen line 0
  logic [7:0]       mem [Cells];

  // (a + b) mod ROWS for operands already below ROWS.
  function automatic logic [4:0] wrap_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [AddrW-1:0] cell_addr(input logic [4:0] phys,
                                                 input logic [AddrW-1:0] x);
    return AddrW'(phys) * AddrW'(COLS) + x;
  endfunction

  // Key decode
  logic       accept, is_print, is_enter, is_bksp, newline;
  logic [4:0] cur_phys, bot_phys;

  assign accept   = key_valid && key_ready;
  assign is_print = (key_in >= 8'h20) && (key_in <= 8'h7e);
  assign is_enter = (key_in == 8'h0a);
  assign is_bksp  = (key_in == 8'h08) && (cur_x != 7'd0);
  assign newline  = accept && (is_enter || (is_print && cur_x == 7'(COLS - 1)));
  assign cur_phys = wrap_add(cur_y, top);
  // Already uses the new top during SCROLL, so this is the line just rotated out.
  assign bot_phys = wrap_add(5'(ROWS - 1), top);

  // Single write port
  logic             we;
  logic [AddrW-1:0] waddr;
  logic [7:0]       wdata;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = 8'h00;
    case (state)
      StClear: begin
        we    = 1'b1;
        waddr = cnt;
      end
      StScroll: begin
        we    = 1'b1;
        waddr = cell_addr(bot_phys, cnt);
      end
      default: begin
        if (accept && is_print) begin
          we    = 1'b1;
          waddr = cell_addr(cur_phys, AddrW'(cur_x));
          wdata = key_in;
        end else if (accept && is_bksp) begin
          we    = 1'b1;
          waddr = cell_addr(cur_phys, AddrW'(cur_x - 7'd1));
        end
      end
    endcase
    if (reset) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Control FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StClear;
      cnt       <= '0;
      top       <= 5'd0;
      cur_x     <= 7'd0;
      cur_y     <= 5'd0;
      key_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        StClear: begin
          if (cnt == AddrW'(Cells - 1)) begin
            state     <= StIdle;
            cnt       <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StScroll: begin
          if (cnt == AddrW'(COLS - 1)) begin
            state     <= StIdle;
            cnt       <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (newline) begin
            cur_x <= 7'd0;
            if (cur_y != 5'(ROWS - 1)) begin
              cur_y <= cur_y + 5'd1;
            end else begin
              top       <= wrap_add(top, 5'd1);
              state     <= StScroll;
              cnt       <= '0;
              key_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end else if (accept && is_print) begin
            cur_x <= cur_x + 7'd1;
          end else if (accept && is_bksp) begin
            cur_x <= cur_x - 7'd1;
          end
        end
      endcase
    end
  end

  // Read path
  logic [9:0]       cx, cy;
  logic [3:0]       px, py;
  logic             in_range;
  logic [AddrW-1:0] raddr;

  always_comb begin
    cx       = h_addr / 10'(CHAR_W);
    cy       = v_addr / 10'(CHAR_H);
    px       = 4'(14'(h_addr) - 14'(cx) * 14'(CHAR_W));
    py       = 4'(14'(v_addr) - 14'(cy) * 14'(CHAR_H));
    in_range = (cx < 10'(COLS)) && (cy < 10'(ROWS));
    // Only meaningful when in_range; cy then fits in five bits.
    raddr    = cell_addr(wrap_add(cy[4:0], top), AddrW'(cx));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ascii_out <= 8'h00;
      row       <= 4'd0;
      col       <= 4'd0;
    end else begin
      ascii_out <= in_range ? mem[raddr] : 8'h00;
      row       <= py;
      col       <= px;
    end
  end

endmodule

// File: tb/tb_vga_text_buffer.sv
// Self-checking bench for vga_text_buffer. A screen-relative model, in which
// scrolling shifts whole lines, predicts every output on every cycle. Directed
// sequences then pin key cases to literal values.
module tb_vga_text_buffer;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CW    = 9;
  localparam int CH    = 16;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] key_in = 8'h00;
  logic       key_valid = 1'b0;
  logic [9:0] h_addr = 10'd0;
  logic [9:0] v_addr = 10'd0;
  logic       key_ready, busy;
  logic [7:0] ascii_out;
  logic [3:0] row, col;
  logic [6:0] cur_x;
  logic [4:0] cur_y;

  vga_text_buffer #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CW), .CHAR_H(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .h_addr    (h_addr),
    .v_addr    (v_addr),
    .ascii_out (ascii_out),
    .row       (row),
    .col       (col),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: screen is indexed by screen line, not by physical line.
  bit         m_on = 1'b0;
  int         m_clr, m_scr, m_x, m_y;
  logic [7:0] scr [ROWS][COLS];
  logic [7:0] tmp [COLS];
  int         e_ascii, e_row, e_col;
  bit         e_chk;
  int         mcx, mcy;
  bit         nl;

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1'b1; m_clr = CELLS; m_scr = 0; m_x = 0; m_y = 0;
      e_ascii = 0; e_row = 0; e_col = 0; e_chk = 1'b1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    end else if (m_on) begin
      mcx = int'(h_addr) / CW;
      mcy = int'(v_addr) / CH;
      e_row = int'(v_addr) % CH;
      e_col = int'(h_addr) % CW;
      e_chk = (m_clr == 0);
      e_ascii = (mcx < COLS && mcy < ROWS) ? int'(scr[mcy][mcx]) : 0;
      if (m_clr > 0) begin
        m_clr--;
      end else if (m_scr > 0) begin
        scr[ROWS-1][COLS-m_scr] = 8'h00;
        m_scr--;
      end else if (key_valid) begin
        nl = 1'b0;
        if (key_in >= 8'h20 && key_in <= 8'h7e) begin
          scr[m_y][m_x] = key_in;
          if (m_x < COLS - 1) m_x++;
          else nl = 1'b1;
        end else if (key_in == 8'h0a) begin
          nl = 1'b1;
        end else if (key_in == 8'h08 && m_x > 0) begin
          m_x--;
          scr[m_y][m_x] = 8'h00;
        end
        if (nl) begin
          m_x = 0;
          if (m_y < ROWS - 1) begin
            m_y++;
          end else begin
            // The line rotated out reappears at the bottom until swept.
            for (int c = 0; c < COLS; c++) tmp[c] = scr[0][c];
            for (int r = 0; r < ROWS - 1; r++)
              for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = tmp[c];
            m_scr = COLS;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("key_ready", int'(key_ready), int'(m_clr == 0 && m_scr == 0));
      check("busy", int'(busy), int'(m_clr != 0 || m_scr != 0));
      check("cur_x", int'(cur_x), m_x);
      check("cur_y", int'(cur_y), m_y);
      check("row", int'(row), e_row);
      check("col", int'(col), e_col);
      if (e_chk) check("ascii_out", int'(ascii_out), e_ascii);
    end
  end

  // Stimulus
  bit rand_hv = 1'b1;

  task automatic tick();
    @(negedge clk);
    if (rand_hv) begin
      h_addr = 10'($urandom_range(0, 799));
      v_addr = 10'($urandom_range(0, 524));
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!key_ready && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("wait_ready_timeout", int'(key_ready), 1);
  endtask

  task automatic send_key(input logic [7:0] k);
    int n;
    n = 0;
    key_in = k;
    key_valid = 1'b1;
    while (!key_ready && n < 5000) begin
      tick();
      n++;
    end
    if (!key_ready) check("send_key_timeout", int'(key_ready), 1);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic read_at(input int h, input int v, output int a);
    h_addr = 10'(h);
    v_addr = 10'(v);
    tick();
    a = int'(ascii_out);
  endtask

  task automatic scan_all();
    rand_hv = 1'b0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        h_addr = 10'(x * CW);
        v_addr = 10'(y * CH);
        tick();
      end
  endtask

  initial begin
    int n, a, r;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    wait_ready(n);
    check("clear_len", n, 2100);
    check("reset_cur_x", int'(cur_x), 0);
    check("reset_cur_y", int'(cur_y), 0);
    scan_all();

    send_key(8'h48);
    send_key(8'h69);
    check("hi_cur_x", int'(cur_x), 2);
    read_at(9, 0, a);
    check("read_h9_ascii", a, 8'h69);
    check("read_h9_col", int'(col), 0);
    read_at(0, 0, a);
    check("read_h0_ascii", a, 8'h48);

    for (int i = 0; i < 68; i++) send_key(8'(8'h41 + i % 26));
    check("wrap_cur_x", int'(cur_x), 0);
    check("wrap_cur_y", int'(cur_y), 1);
    send_key(8'h0a);
    check("enter_cur_y", int'(cur_y), 2);

    send_key(8'h08);
    check("bksp_x0_x", int'(cur_x), 0);
    check("bksp_x0_y", int'(cur_y), 2);
    send_key(8'h41);
    check("a_cur_x", int'(cur_x), 1);
    send_key(8'h08);
    check("bksp_cur_x", int'(cur_x), 0);
    read_at(0, 32, a);
    check("bksp_cleared", a, 0);

    send_key(8'h51);
    send_key(8'h52);
    repeat (27) send_key(8'h0a);
    check("fill_cur_y", int'(cur_y), 29);
    read_at(0, 0, a);
    check("pre_scroll_00", a, 8'h48);
    send_key(8'h0a);
    key_in = 8'h58;
    key_valid = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("scroll_len", n, 70);
    key_valid = 1'b0;
    check("scroll_cur_x", int'(cur_x), 0);
    check("scroll_cur_y", int'(cur_y), 29);
    read_at(0, 16, a);
    check("post_scroll_q", a, 8'h51);
    read_at(0, 0, a);
    check("post_scroll_00", a, 0);
    for (int x = 0; x < COLS; x++) begin
      h_addr = 10'(x * CW);
      v_addr = 10'(29 * CH);
      tick();
    end

    rand_hv = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) key_in = 8'h0a;
      else if (r == 1) key_in = 8'h08;
      else if (r == 2) key_in = 8'($urandom_range(0, 255));
      else key_in = 8'($urandom_range(32, 126));
      key_valid = 1'($urandom_range(0, 1));
      tick();
    end
    key_valid = 1'b0;

    wait_ready(n);
    for (int i = 0; i < 40 && !busy; i++) send_key(8'h0a);
    repeat (30) tick();
    check("mid_scroll_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(n);
    check("clear_len_scroll_rst", n, 2100);
    check("rst_cur_x", int'(cur_x), 0);
    check("rst_cur_y", int'(cur_y), 0);

    repeat (1000) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(n);
    check("clear_len_clear_rst", n, 2100);
    scan_all();
    send_key(8'h4b);
    read_at(0, 0, a);
    check("after_clear_k", a, 8'h4b);
    read_at(640, 0, a);
    check("h640_ascii", a, 0);
    check("h640_col", int'(col), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
